// File: rtl/dvi_timing_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dvi_timing_ctrl_pkg
// Brief   : Shared 640x480@60 timing defaults, run-FSM encodings and helpers.
// Revision: 1.0 - initial release
// ============================================================================
package dvi_timing_ctrl_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
   localparam int DEF_XW       = 11;
   localparam int DEF_YW       = 10;

   typedef logic [1:0] run_state_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   // Electrical level of a sync line given its logical state and polarity.
   function automatic logic sync_level(input logic is_active, input logic pol);
      return is_active ? pol : ~pol;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dvi_timing_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : dvi_timing_ctrl_if
// Brief   : Raster control/timing bundle between the timing controller and sinks.
// Revision: 1.0 - initial release
// ============================================================================
interface dvi_timing_ctrl_if
   import dvi_timing_ctrl_pkg::*;
#(
   parameter int XW = DEF_XW,
   parameter int YW = DEF_YW
) ();

   logic          enable;
   logic          busy;
   logic          pixel_req;
   logic [XW-1:0] req_x;
   logic [YW-1:0] req_y;
   logic          de;
   logic          hsync;
   logic          vsync;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          frame_start;
   logic          line_start;

   modport master (
      input  enable,
      output busy, pixel_req, req_x, req_y, de, hsync, vsync, x, y,
             frame_start, line_start
   );

   modport slave (
      output enable,
      input  busy, pixel_req, req_x, req_y, de, hsync, vsync, x, y,
             frame_start, line_start
   );

endinterface
`default_nettype wire

// File: rtl/dvi_timing_ctrl_axis_counter.sv
`default_nettype none
// ============================================================================
// Module  : timing_axis_counter
// Brief   : One raster axis: slot counter ACTIVE->FP->SYNC->BP with decodes.
// Revision: 1.0 - initial release
// ============================================================================
module timing_axis_counter
   import dvi_timing_ctrl_pkg::*;
#(
   parameter int ACTIVE = DEF_H_ACTIVE,
   parameter int FP     = DEF_H_FP,
   parameter int SYNC   = DEF_H_SYNC,
   parameter int BP     = DEF_H_BP,
   parameter bit POL    = 1'b0,
   parameter int W      = DEF_XW
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         step,
   input  logic         clr,
   output logic [W-1:0] count,
   output logic         active,
   output logic         sync,
   output logic         last
);

   localparam int         TOTAL      = ACTIVE + FP + SYNC + BP;
   localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
   localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
   localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);
   localparam logic [W-1:0] LAST_CNT   = W'(TOTAL - 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (step) begin
         count <= last ? '0 : count + 1'b1;
      end
   end

   assign active = (count < ACT_END);
   assign last   = (count == LAST_CNT);
   assign sync   = sync_level((count >= SYNC_START) && (count < SYNC_END), POL);

endmodule
`default_nettype wire

// File: rtl/dvi_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dvi_timing_ctrl
// Brief   : DVI raster timing with one-cycle-early pixel request and
//           frame-aligned start/stop.
// Revision: 1.0 - initial release
// ============================================================================
module dvi_timing_ctrl
   import dvi_timing_ctrl_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int XW       = DEF_XW,
   parameter int YW       = DEF_YW
) (
   input  logic               clk_pixel,
   input  logic               rst,
   dvi_timing_ctrl_if.master  vid
);

   run_state_t    state;
   logic          la_valid;
   logic [XW-1:0] h_count;
   logic [YW-1:0] v_count;
   logic          h_active, h_sync, h_last;
   logic          v_active, v_sync, v_last;
   logic          h_step, v_step, cnt_clr, la_last;

   logic          de_q, hs_q, vs_q, fs_q, ls_q;
   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;

   // The axis counters address the look-ahead slot, one cycle ahead of the outputs.
   assign h_step  = la_valid;
   assign v_step  = la_valid & h_last;
   assign cnt_clr = (state == ST_IDLE);
   assign la_last = h_last & v_last;

   timing_axis_counter #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .W(XW)
   ) u_h_axis (
      .clk(clk_pixel), .rst(rst), .step(h_step), .clr(cnt_clr),
      .count(h_count), .active(h_active), .sync(h_sync), .last(h_last)
   );

   timing_axis_counter #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .W(YW)
   ) u_v_axis (
      .clk(clk_pixel), .rst(rst), .step(v_step), .clr(cnt_clr),
      .count(v_count), .active(v_active), .sync(v_sync), .last(v_last)
   );

   // Stop only when the look-ahead is on the final slot, so frames are never cut.
   always_ff @(posedge clk_pixel or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         la_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (vid.enable) begin
                  state    <= ST_RUN;
                  la_valid <= 1'b1;
               end
            end
            ST_RUN, ST_DRAIN: begin
               if (!la_valid) begin
                  state <= ST_IDLE;
               end else if (la_last && !vid.enable) begin
                  state    <= ST_DRAIN;
                  la_valid <= 1'b0;
               end else begin
                  state <= vid.enable ? ST_RUN : ST_DRAIN;
               end
            end
            default: begin
               state    <= ST_IDLE;
               la_valid <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_pixel or posedge rst) begin
      if (rst) begin
         x_q  <= '0;
         y_q  <= '0;
         de_q <= 1'b0;
         hs_q <= ~HS_POL;
         vs_q <= ~VS_POL;
         fs_q <= 1'b0;
         ls_q <= 1'b0;
      end else if (la_valid) begin
         x_q  <= h_count;
         y_q  <= v_count;
         de_q <= h_active & v_active;
         hs_q <= h_sync;
         vs_q <= v_sync;
         fs_q <= (h_count == '0) && (v_count == '0);
         ls_q <= (h_count == '0);
      end else begin
         x_q  <= '0;
         y_q  <= '0;
         de_q <= 1'b0;
         hs_q <= ~HS_POL;
         vs_q <= ~VS_POL;
         fs_q <= 1'b0;
         ls_q <= 1'b0;
      end
   end

   assign vid.busy        = (state != ST_IDLE);
   assign vid.pixel_req   = la_valid & h_active & v_active;
   assign vid.req_x       = h_count;
   assign vid.req_y       = v_count;
   assign vid.de          = de_q;
   assign vid.hsync       = hs_q;
   assign vid.vsync       = vs_q;
   assign vid.x           = x_q;
   assign vid.y           = y_q;
   assign vid.frame_start = fs_q;
   assign vid.line_start  = ls_q;

endmodule
`default_nettype wire

// File: tb/tb_dvi_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dvi_timing_ctrl
// Brief   : Scoreboard bench for dvi_timing_ctrl on a 15x8 reduced raster.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dvi_timing_ctrl;

   localparam int HT = 15;
   localparam int VT = 8;

   typedef struct packed {
      logic [3:0] x;
      logic [2:0] y;
      logic       de;
      logic       hs;
      logic       vs;
      logic       fs;
      logic       ls;
   } slot_t;

   logic  clk_pixel = 1'b0;
   logic  rst = 1'b1;
   int    vectors = 0;
   int    miscompares = 0;
   int    cyc = 0;
   slot_t sb[$];

   always #5 clk_pixel = ~clk_pixel;
   always @(posedge clk_pixel) cyc <= cyc + 1;

   dvi_timing_ctrl_if #(.XW(4), .YW(3)) vid ();
   dvi_timing_ctrl_if #(.XW(4), .YW(3)) vp ();
   assign vp.enable = vid.enable;

   dvi_timing_ctrl #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .XW(4), .YW(3)
   ) dut (.clk_pixel(clk_pixel), .rst(rst), .vid(vid));

   dvi_timing_ctrl #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .XW(4), .YW(3)
   ) dut_pol (.clk_pixel(clk_pixel), .rst(rst), .vid(vp));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Hand-derived raster: active 8x4, hsync low at x=10..12, vsync low on lines 5..6.
   task automatic push_frame();
      slot_t s;
      for (int yy = 0; yy < VT; yy++) begin
         for (int xx = 0; xx < HT; xx++) begin
            s.x  = 4'(xx);
            s.y  = 3'(yy);
            s.de = (xx < 8) && (yy < 4);
            s.hs = !(xx >= 10 && xx <= 12);
            s.vs = !(yy == 5 || yy == 6);
            s.fs = (xx == 0) && (yy == 0);
            s.ls = (xx == 0);
            sb.push_back(s);
         end
      end
   endtask

   // Monitor: every live slot (x != 0 or line_start) pops and checks one entry.
   slot_t       e;
   logic        prev_pr;
   logic [3:0]  prev_rx;
   logic [2:0]  prev_ry;
   bit          prev_ok = 1'b0;
   int          de_cnt = 0;
   int          hs_cnt = 0;
   int          fs_prev = -1;
   int          fs_last = -1;

   always @(negedge clk_pixel) begin
      if (rst) begin
         prev_ok = 1'b0;
      end else begin
         if (prev_ok) begin
            chk("pixel_req_leads_de", {31'd0, vid.de}, {31'd0, prev_pr});
            if (prev_pr)
               chk("req_xy_leads_xy", {25'd0, vid.x, vid.y}, {25'd0, prev_rx, prev_ry});
         end
         prev_pr = vid.pixel_req;
         prev_rx = vid.req_x;
         prev_ry = vid.req_y;
         prev_ok = 1'b1;
         if (vid.frame_start) begin
            fs_prev = fs_last;
            fs_last = cyc;
         end
         if (vid.line_start || vid.x != 4'd0) begin
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_slot: got (%0d,%0d), expected no slot", vid.x, vid.y);
            end else begin
               e = sb.pop_front();
               chk("slot", {21'd0, vid.x, vid.y, vid.de, vid.hsync, vid.vsync,
                            vid.frame_start, vid.line_start}, {21'd0, e});
               chk("pol_slot", {29'd0, vp.hsync, vp.vsync, vp.de}, {29'd0, ~e.hs, ~e.vs, e.de});
               if (e.fs) de_cnt = 0;
               if (e.ls) hs_cnt = 0;
               de_cnt += int'(vid.de);
               hs_cnt += int'(!vid.hsync);
               if (e.x == 4'd14) chk("hsync_low_slots", hs_cnt, 3);
               if (e.x == 4'd14 && e.y == 3'd7) chk("de_slots_per_frame", de_cnt, 32);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_pixel);
      #1;
   endtask

   task automatic wait_slot(input int xx, input int yy);
      bit found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         tick();
         if (vid.busy && vid.x == 4'(xx) && vid.y == 3'(yy)) found = 1'b1;
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("FAIL wait_slot: got no slot (%0d,%0d), expected within 400 cycles", xx, yy);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_idle"}, {11'd0, vid.de, vid.pixel_req, vid.frame_start, vid.line_start,
                           vid.busy, vid.hsync, vid.vsync, vid.x, vid.y, vid.req_x, vid.req_y},
          {11'd0, 5'b00000, 2'b11, 14'd0});
      chk({tag, "_pol_idle"}, {29'd0, vp.hsync, vp.vsync, vp.busy}, 32'd0);
   endtask

   // Enable (or reset release) takes effect at the next edge: req at N+1, de at N+2.
   task automatic start_check(input string tag);
      chk({tag, "_N_req"}, {31'd0, vid.pixel_req}, 32'd0);
      tick();
      chk({tag, "_N1_req"}, {22'd0, vid.pixel_req, vid.busy, vid.req_x, vid.req_y, vid.de},
          {22'd0, 1'b1, 1'b1, 4'd0, 3'd0, 1'b0});
      tick();
      chk({tag, "_N2_de"}, {22'd0, vid.de, vid.frame_start, vid.line_start, vid.x, vid.y},
          {22'd0, 3'b111, 4'd0, 3'd0});
   endtask

   initial begin
      bit quiet_bad;
      vid.enable = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      check_idle("reset");
      rst = 1'b0;
      repeat (2) tick();
      check_idle("released");

      // Free run of several frames, then stop mid-frame.
      repeat (4) push_frame();
      vid.enable = 1'b1;
      start_check("start1");
      repeat (4) wait_slot(3, 2);
      vid.enable = 1'b0;
      tick();
      chk("drain_busy1", {31'd0, vid.busy}, 32'd1);
      wait_slot(14, 7);
      chk("last_slot_no_req", {30'd0, vid.pixel_req, vid.busy}, {30'd0, 1'b0, 1'b1});
      tick();
      check_idle("drain_end1");
      quiet_bad = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (vid.pixel_req || vid.busy || vid.de) quiet_bad = 1'b1;
      end
      chk("idle_quiet", {31'd0, quiet_bad}, 32'd0);
      chk("sb_empty1", sb.size(), 0);

      // Re-raise during drain: the raster continues without a gap.
      push_frame();
      vid.enable = 1'b1;
      start_check("start2");
      wait_slot(3, 2);
      vid.enable = 1'b0;
      tick();
      chk("drain_busy2", {31'd0, vid.busy}, 32'd1);
      wait_slot(7, 5);
      push_frame();
      vid.enable = 1'b1;
      wait_slot(1, 0);
      chk("frame_start_interval", fs_last - fs_prev, 120);
      wait_slot(3, 2);
      vid.enable = 1'b0;
      wait_slot(14, 7);
      tick();
      check_idle("drain_end2");
      chk("sb_empty2", sb.size(), 0);

      // Asynchronous reset mid-frame, release with enable held high.
      repeat (2) push_frame();
      vid.enable = 1'b1;
      start_check("start3");
      wait_slot(5, 1);
      rst = 1'b1;
      #1;
      check_idle("async_rst");
      sb.delete();
      repeat (2) tick();
      rst = 1'b0;
      push_frame();
      start_check("restart");
      wait_slot(3, 2);
      vid.enable = 1'b0;
      wait_slot(14, 7);
      tick();
      check_idle("final");
      repeat (3) tick();
      chk("sb_empty3", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish within 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
